// File: rtl/byte_ram_pkg.sv
// Shared sizing for the CPU data memory: address/bus widths and byte-lane layout.
// Imported by the RAM and by anything that needs the same word/byte split.
package byte_ram_pkg;

  localparam int ADDR_SIZE_DEF  = 8;
  localparam int WORD_SIZE_DEF  = 16;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 2;

  typedef logic [BYTE_W-1:0] byte_t;

  // Bit offset of a byte lane within a bus word.
  function automatic int unsigned lane_lsb(input int unsigned lane);
    return lane * BYTE_W;
  endfunction

endpackage

// File: rtl/byte_ram.sv
// Byte-addressed little-endian RAM on a shared tri-state 16-bit bus.
// Writes commit on the rising clk edge; reads are combinational; sync active-high reset clears all bytes.
module byte_ram
  import byte_ram_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] addr,
  inout  logic [WORD_SIZE-1:0] data
);

  localparam int DEPTH  = 1 << ADDR_SIZE;
  localparam int LO_LSB = lane_lsb(0);
  localparam int HI_LSB = lane_lsb(BYTES_PER_WORD - 1);

  byte_t                mem [DEPTH];
  logic [ADDR_SIZE-1:0] addr_hi;
  logic [WORD_SIZE-1:0] rd_word;

  // Natural ADDR_SIZE-wide overflow gives the modulo wrap for the high byte.
  assign addr_hi = addr + ADDR_SIZE'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[addr]    <= data[LO_LSB +: BYTE_W];
      mem[addr_hi] <= data[HI_LSB +: BYTE_W];
    end
  end

  assign rd_word = {mem[addr_hi], mem[addr]};

  // Release the bus whenever the CPU owns it, reset included.
  assign data = wr_en ? {WORD_SIZE{1'bz}} : rd_word;

endmodule

// File: tb/tb_byte_ram.sv
// Scoreboarded bench for byte_ram: stimulus pushes expected bus words, a monitor pops and compares.
module tb_byte_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  addr = '0;
  logic        drv_en = 1'b0;
  logic [15:0] drv_dat = '0;
  wire  [15:0] data;

  logic        rd_vld = 1'b0;
  string       rd_name = "";

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  ref_mem [256];
  logic [15:0] exp_q [$];

  assign data = drv_en ? drv_dat : 16'hzzzz;

  always #5 clk = ~clk;

  byte_ram dut (
    .clk  (clk),
    .rst  (rst),
    .wr_en(wr_en),
    .addr (addr),
    .data (data)
  );

  // Reference model: a plain byte array, word = two consecutive bytes with wrap.
  function automatic logic [15:0] model_read(input int a);
    return {ref_mem[(a + 1) % 256], ref_mem[a % 256]};
  endfunction

  task automatic model_write(input int a, input logic [15:0] d);
    ref_mem[a % 256]       = d[7:0];
    ref_mem[(a + 1) % 256] = d[15:8];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
  endtask

  // Monitor: samples on the falling edge, away from the write edge.
  always @(negedge clk) begin
    logic [15:0] exp;
    if (rd_vld) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: read with empty scoreboard, got %h", rd_name, data);
      end else begin
        exp = exp_q.pop_front();
        if (data !== exp) begin
          n_fail++;
          $display("FAIL %s addr=%0d: got %h expected %h", rd_name, addr, data, exp);
        end
      end
    end else if (wr_en && drv_en) begin
      // While the CPU drives, the bus must carry exactly the CPU's value.
      n_tests++;
      if (data !== drv_dat) begin
        n_fail++;
        $display("FAIL bus_own addr=%0d: got %h expected %h", addr, data, drv_dat);
      end
    end
  end

  task automatic do_write(input int a, input logic [15:0] d, input logic with_rst);
    rst     = with_rst;
    wr_en   = 1'b1;
    drv_en  = 1'b1;
    addr    = 8'(a);
    drv_dat = d;
    @(posedge clk);
    #1;
    if (with_rst) model_reset();
    else          model_write(a, d);
    rst    = 1'b0;
    drv_en = 1'b0;
    wr_en  = 1'b0;
  endtask

  task automatic do_read(input int a, input string nm);
    rst     = 1'b0;
    wr_en   = 1'b0;
    drv_en  = 1'b0;
    addr    = 8'(a);
    rd_name = nm;
    exp_q.push_back(model_read(a));
    rd_vld  = 1'b1;
    @(posedge clk);
    #1;
    rd_vld  = 1'b0;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    wr_en  = 1'b0;
    drv_en = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] blist [16];
    int         op;
    int         a;

    blist = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8,
              8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};

    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 20; i++) do_read(i, "reset_zero");

    for (int i = 0; i < 16; i += 2) do_write(i, {blist[i+1], blist[i]}, 1'b0);
    for (int i = 0; i < 20; i += 2) do_read(i, "aligned");

    do_write(1, 16'hBEEF, 1'b0);
    do_read(0, "misaligned_lo");
    do_read(2, "misaligned_hi");

    do_write(255, 16'hA55A, 1'b0);
    do_read(255, "wrap");
    do_read(0, "wrap_low0");

    do_write(4, 16'h1234, 1'b1);
    do_read(4, "rst_priority");
    do_read(0, "rst_clear");

    // Randomised mix: back-to-back/overlapping writes, reads, rare reset-with-write.
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 39);
      a  = (op < 30) ? $urandom_range(0, 15) : $urandom_range(0, 255);
      if (op == 0)      do_write(a, 16'($urandom), 1'b1);
      else if (op < 18) do_write(a, 16'($urandom), 1'b0);
      else              do_read(a, "random");
    end

    @(posedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
